// File: rtl/rc4_pkg.sv
// rc4_pkg: shared types and constants for the RC4 decrypt datapath.
//   compute_state_t : states of the keystream/XOR phase engine
//   S_DEPTH         : number of entries in the S permutation memory
//   BYTE_W          : byte width of S, ciphertext and plaintext data
//   DEF_MSG_LEN     : default message length in bytes
package rc4_pkg;

  localparam int S_DEPTH     = 256;
  localparam int BYTE_W      = 8;
  localparam int DEF_MSG_LEN = 32;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INC_I     = 4'd1,
    WAIT_SI   = 4'd2,
    READ_SI   = 4'd3,
    WAIT_SJ   = 4'd4,
    READ_SJ   = 4'd5,
    WRITE_I   = 4'd6,
    WRITE_J   = 4'd7,
    ADDR_F    = 4'd8,
    WAIT_F    = 4'd9,
    READ_F    = 4'd10,
    WRITE_DEC = 4'd11,
    DONE      = 4'd12
  } compute_state_t;

endpackage

// File: rtl/rc4_compute_if.sv
// rc4_compute_if: bundles the compute-phase handshake and the three memory
// buses (S memory, ciphertext ROM, plaintext RAM).
//   master : the compute engine (drives addresses, write data, complete)
//   slave  : sequencer + memories (drive start and read data)
interface rc4_compute_if
  import rc4_pkg::*;
#(
  parameter int MSG_AW = 5
);

  logic              compute_start;
  logic              compute_complete;
  logic [BYTE_W-1:0] address_compute;
  logic [BYTE_W-1:0] data_compute;
  logic              wren_compute;
  logic [BYTE_W-1:0] q_compute;
  logic [MSG_AW-1:0] rom_address;
  logic [BYTE_W-1:0] rom_q;
  logic [MSG_AW-1:0] dec_address;
  logic [BYTE_W-1:0] dec_data;
  logic              dec_wren;

  modport master (
    input  compute_start, q_compute, rom_q,
    output compute_complete, address_compute, data_compute, wren_compute,
           rom_address, dec_address, dec_data, dec_wren
  );

  modport slave (
    output compute_start, q_compute, rom_q,
    input  compute_complete, address_compute, data_compute, wren_compute,
           rom_address, dec_address, dec_data, dec_wren
  );

endinterface

// File: rtl/rc4_compute.sv
// rc4_compute: RC4 PRGA phase engine. On compute_start it walks the
// already-shuffled S memory, swapping S[i]/S[j] in place, and writes
// dec[k] = S[S[i]+S[j]] ^ rom[k] for k = 0..MSG_LEN-1. It then holds
// compute_complete until compute_start is withdrawn.
// Ports:
//   clk     : single clock
//   reset_n : asynchronous active-low reset
//   bus     : rc4_compute_if.master (handshake, S memory, ROM, RAM)
// All outputs are registered. Memories are synchronous: an address driven on
// one edge is sampled back two edges later, hence the WAIT_* states.
module rc4_compute
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = DEF_MSG_LEN,
  parameter int MSG_AW  = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  rc4_compute_if.master bus
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);
  localparam logic [MSG_AW-1:0] K_ONE  = MSG_AW'(1);

  compute_state_t    state_r, state_nxt_s;
  logic [BYTE_W-1:0] i_r, i_nxt_s, j_r, j_nxt_s;
  logic [BYTE_W-1:0] si_r, si_nxt_s, sj_r, sj_nxt_s;
  logic [BYTE_W-1:0] f_r, f_nxt_s, ct_r, ct_nxt_s;
  logic [MSG_AW-1:0] k_r, k_nxt_s;
  logic [BYTE_W-1:0] addr_r, addr_nxt_s, data_r, data_nxt_s;
  logic              wren_r, wren_nxt_s;
  logic [MSG_AW-1:0] rom_addr_r, rom_addr_nxt_s;
  logic [MSG_AW-1:0] dec_addr_r, dec_addr_nxt_s;
  logic [BYTE_W-1:0] dec_data_r, dec_data_nxt_s;
  logic              dec_wren_r, dec_wren_nxt_s;
  logic              complete_r, complete_nxt_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output logic; write strobes default low every cycle.
  always_comb begin
    state_nxt_s    = state_r;
    i_nxt_s        = i_r;
    j_nxt_s        = j_r;
    k_nxt_s        = k_r;
    si_nxt_s       = si_r;
    sj_nxt_s       = sj_r;
    f_nxt_s        = f_r;
    ct_nxt_s       = ct_r;
    addr_nxt_s     = addr_r;
    data_nxt_s     = data_r;
    rom_addr_nxt_s = rom_addr_r;
    dec_addr_nxt_s = dec_addr_r;
    dec_data_nxt_s = dec_data_r;
    wren_nxt_s     = 1'b0;
    dec_wren_nxt_s = 1'b0;
    complete_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.compute_start) begin
          state_nxt_s = INC_I;
          i_nxt_s     = 8'd0;
          j_nxt_s     = 8'd0;
          k_nxt_s     = {MSG_AW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      INC_I: begin
        i_nxt_s     = i_r + 8'd1;
        addr_nxt_s  = i_r + 8'd1;
        state_nxt_s = WAIT_SI;
      end
      WAIT_SI: state_nxt_s = READ_SI;
      READ_SI: begin
        si_nxt_s    = bus.q_compute;
        j_nxt_s     = j_r + bus.q_compute;
        addr_nxt_s  = j_r + bus.q_compute;
        state_nxt_s = WAIT_SJ;
      end
      WAIT_SJ: state_nxt_s = READ_SJ;
      READ_SJ: begin
        sj_nxt_s    = bus.q_compute;
        state_nxt_s = WRITE_I;
      end
      // When i==j both writes hit the same entry with si==sj, so S is unchanged.
      WRITE_I: begin
        addr_nxt_s  = i_r;
        data_nxt_s  = sj_r;
        wren_nxt_s  = 1'b1;
        state_nxt_s = WRITE_J;
      end
      WRITE_J: begin
        addr_nxt_s  = j_r;
        data_nxt_s  = si_r;
        wren_nxt_s  = 1'b1;
        state_nxt_s = ADDR_F;
      end
      // si+sj is the same before and after the swap, so captured values suffice.
      ADDR_F: begin
        addr_nxt_s     = si_r + sj_r;
        rom_addr_nxt_s = k_r;
        state_nxt_s    = WAIT_F;
      end
      WAIT_F: state_nxt_s = READ_F;
      READ_F: begin
        f_nxt_s     = bus.q_compute;
        ct_nxt_s    = bus.rom_q;
        state_nxt_s = WRITE_DEC;
      end
      WRITE_DEC: begin
        dec_addr_nxt_s = k_r;
        dec_data_nxt_s = f_r ^ ct_r;
        dec_wren_nxt_s = 1'b1;
        if (k_r == K_LAST) begin
          state_nxt_s = DONE;
        end else begin
          k_nxt_s     = k_r + K_ONE;
          state_nxt_s = INC_I;
        end
      end
      DONE: begin
        if (bus.compute_start) begin
          complete_nxt_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_r        <= 8'd0;
      j_r        <= 8'd0;
      k_r        <= {MSG_AW{1'b0}};
      si_r       <= 8'd0;
      sj_r       <= 8'd0;
      f_r        <= 8'd0;
      ct_r       <= 8'd0;
      addr_r     <= 8'd0;
      data_r     <= 8'd0;
      wren_r     <= 1'b0;
      rom_addr_r <= {MSG_AW{1'b0}};
      dec_addr_r <= {MSG_AW{1'b0}};
      dec_data_r <= 8'd0;
      dec_wren_r <= 1'b0;
      complete_r <= 1'b0;
    end else begin
      i_r        <= i_nxt_s;
      j_r        <= j_nxt_s;
      k_r        <= k_nxt_s;
      si_r       <= si_nxt_s;
      sj_r       <= sj_nxt_s;
      f_r        <= f_nxt_s;
      ct_r       <= ct_nxt_s;
      addr_r     <= addr_nxt_s;
      data_r     <= data_nxt_s;
      wren_r     <= wren_nxt_s;
      rom_addr_r <= rom_addr_nxt_s;
      dec_addr_r <= dec_addr_nxt_s;
      dec_data_r <= dec_data_nxt_s;
      dec_wren_r <= dec_wren_nxt_s;
      complete_r <= complete_nxt_s;
    end
  end

  assign bus.address_compute  = addr_r;
  assign bus.data_compute     = data_r;
  assign bus.wren_compute     = wren_r;
  assign bus.rom_address      = rom_addr_r;
  assign bus.dec_address      = dec_addr_r;
  assign bus.dec_data         = dec_data_r;
  assign bus.dec_wren         = dec_wren_r;
  assign bus.compute_complete = complete_r;

endmodule
